pipe_skid_stage: RTL

//  Consumer-side pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_skid_stage_pkg.sv | 11 +
 rtl/pipe_data_reg.sv | 20 ++
 rtl/pipe_skid_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared handshake-stage definitions: state width and occupancy encodings.
// Other valid/ready stages import these so occupancy values mean the same everywhere.
package pipe_skid_stage_pkg;

    localparam int unsigned STATE_BITS = 2;

    localparam logic [STATE_BITS-1:0] PIPE_EMPTY = 2'd0;
    localparam logic [STATE_BITS-1:0] PIPE_ONE   = 2'd1;
    localparam logic [STATE_BITS-1:0] PIPE_FULL  = 2'd2;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and asynchronous active-low clear.
module pipe_data_reg #(
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] d,
    output logic [DATA_BITS-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready, out_valid and occupancy are flop outputs; no combinational ready path.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic [1:0]           occupancy
);

    logic [STATE_BITS-1:0] state;
    logic [STATE_BITS-1:0] state_nxt;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  accept;
    logic                  take;
    logic                  load_main;
    logic                  load_skid;
    logic                  main_from_skid;
    logic [DATA_BITS-1:0]  main_d;
    logic [DATA_BITS-1:0]  main_q;
    logic [DATA_BITS-1:0]  skid_q;

    assign accept = in_valid & in_ready_q;
    assign take   = out_valid_q & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            PIPE_EMPTY: begin
                if (accept) begin
                    state_nxt = PIPE_ONE;
                    load_main = 1'b1;
                end
            end
            PIPE_ONE: begin
                if (accept && take) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_nxt = PIPE_FULL;
                    load_skid = 1'b1;
                end else if (take) begin
                    state_nxt = PIPE_EMPTY;
                end
            end
            PIPE_FULL: begin
                if (take) begin
                    state_nxt      = PIPE_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = PIPE_EMPTY;
        endcase
        // Flush drops everything; data registers keep stale contents since they are don't-care once empty.
        if (flush) begin
            state_nxt = PIPE_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PIPE_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt != PIPE_FULL);
            out_valid_q <= (state_nxt != PIPE_EMPTY);
        end
    end

    pipe_data_reg #(.DATA_BITS(DATA_BITS)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_main),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_reg #(.DATA_BITS(DATA_BITS)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_skid),
        .d     (in_data),
        .q     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state;

endmodule
